// File: rtl/net_udp_rx_unpack.sv
// ---------------------------------------------------------------------------
// net_udp_rx_unpack
//
// Receive-side payload unpacker that follows the UDP receive ports, running
// in the gmii_rx_clk domain. It collects 32-bit words MSB-first into a
// WORDS*32 buffer. On rec_pkt_done it checks the packet length and either
// accepts or rejects the packet. An accepted packet sends the top
// PAYLOAD_BITS of the buffer to o_payload together with a one-cycle
// payload_valid strobe. A rejected packet raises a one-cycle len_err strobe.
//
// Ports:
//   gmii_rx_clk    in   1              clock
//   rst            in   1              synchronous active-high reset
//   rec_en         in   1              rec_data holds a valid word
//   rec_data       in   32             received word, first byte in [31:24]
//   rec_pkt_done   in   1              one-cycle end-of-packet pulse
//   rec_byte_num   in   16             payload byte count (valid with done)
//   o_payload      out  PAYLOAD_BITS   last accepted payload
//   payload_valid  out  1              one-cycle strobe: o_payload updated
//   len_err        out  1              one-cycle strobe: packet rejected
//   good_cnt       out  16             saturating accepted-packet count
//   err_cnt        out  16             saturating rejected-packet count
//
// Build option:
//   UDP_RX_PAD_CHECK_EN  When defined, an accepted packet must also have
//                        all-zero padding bits below the payload. Packets
//                        with nonzero padding are rejected.
//
// State table:
//   state   | meaning
//   IDLE    | no words held
//   RECV    | 1..WORDS words held
//   DROP    | more than WORDS words seen, waiting for rec_pkt_done
// ---------------------------------------------------------------------------
module net_udp_rx_unpack #(
  parameter int PAYLOAD_BITS      = 88,
  parameter int UDP_PAYLOAD_BYTES = (PAYLOAD_BITS + 7) / 8
) (
  input  logic                    gmii_rx_clk,
  input  logic                    rst,
  input  logic                    rec_en,
  input  logic [31:0]             rec_data,
  input  logic                    rec_pkt_done,
  input  logic [15:0]             rec_byte_num,
  output logic [PAYLOAD_BITS-1:0] o_payload,
  output logic                    payload_valid,
  output logic                    len_err,
  output logic [15:0]             good_cnt,
  output logic [15:0]             err_cnt
);

  localparam int WORDS       = (UDP_PAYLOAD_BYTES + 3) / 4;
  localparam int PADDED_BITS = WORDS * 32;
  localparam int PAD_BITS    = PADDED_BITS - PAYLOAD_BITS;
  localparam int WCW         = $clog2(WORDS + 1);

  localparam logic [WCW-1:0] WORDS_C = WCW'(WORDS);
  localparam logic [15:0]    BYTES_C = 16'(UDP_PAYLOAD_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [WCW-1:0]          word_cnt_q, word_cnt_d;
  logic [PADDED_BITS-1:0]  buf_q, buf_d;
  logic [PAYLOAD_BITS-1:0] o_payload_q, o_payload_d;
  logic                    payload_valid_q, payload_valid_d;
  logic                    len_err_q, len_err_d;
  logic [15:0]             good_cnt_q, good_cnt_d;
  logic [15:0]             err_cnt_q, err_cnt_d;

  // Buffer, count and drop flag after this cycle's word (if any) is applied.
  // The close decision uses these so a word arriving with rec_pkt_done counts.
  logic [PADDED_BITS-1:0]  buf_upd;
  logic [WCW-1:0]          cnt_upd;
  logic                    drop_upd;
  logic                    pad_ok;
  logic                    accept;
  logic                    reject;

  // -------------------------------------------------------------------------
  // Word capture
  // -------------------------------------------------------------------------
  always_comb begin
    buf_upd  = buf_q;
    cnt_upd  = word_cnt_q;
    drop_upd = (state_q == S_DROP);
    if (rec_en) begin
      if (word_cnt_q < WORDS_C) begin
        // Constant slice per word slot keeps the write mux explicit.
        for (int w = 0; w < WORDS; w++) begin
          if (word_cnt_q == WCW'(w)) begin
            buf_upd[PADDED_BITS-1-32*w -: 32] = rec_data;
          end
        end
        cnt_upd = word_cnt_q + WCW'(1);
      end else begin
        // Buffer is already full, so this word cannot fit anywhere.
        drop_upd = 1'b1;
      end
    end
  end

`ifdef UDP_RX_PAD_CHECK_EN
  generate
    if (PAD_BITS > 0) begin : g_pad_check
      assign pad_ok = (buf_upd[PAD_BITS-1:0] == '0);
    end else begin : g_no_pad
      assign pad_ok = 1'b1;
    end
  endgenerate
`else
  assign pad_ok = 1'b1;
`endif

  assign accept = rec_pkt_done
                & (rec_byte_num == BYTES_C)
                & (cnt_upd == WORDS_C)
                & ~drop_upd
                & pad_ok;
  assign reject = rec_pkt_done & ~accept;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      word_cnt_q      <= '0;
      buf_q           <= '0;
      o_payload_q     <= '0;
      payload_valid_q <= 1'b0;
      len_err_q       <= 1'b0;
      good_cnt_q      <= '0;
      err_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      word_cnt_q      <= word_cnt_d;
      buf_q           <= buf_d;
      o_payload_q     <= o_payload_d;
      payload_valid_q <= payload_valid_d;
      len_err_q       <= len_err_d;
      good_cnt_q      <= good_cnt_d;
      err_cnt_q       <= err_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    word_cnt_d = cnt_upd;
    buf_d      = buf_upd;
    if (rec_pkt_done) begin
      // Either outcome returns to empty, which makes the next cycle free
      // to start a new packet.
      state_d    = S_IDLE;
      word_cnt_d = '0;
      buf_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (drop_upd) begin
            state_d = S_DROP;
          end else if (cnt_upd != '0) begin
            state_d = S_RECV;
          end
        end
        S_RECV: begin
          if (drop_upd) begin
            state_d = S_DROP;
          end
        end
        S_DROP: begin
          state_d = S_DROP;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    o_payload_d     = o_payload_q;
    payload_valid_d = 1'b0;
    len_err_d       = 1'b0;
    good_cnt_d      = good_cnt_q;
    err_cnt_d       = err_cnt_q;
    if (accept) begin
      o_payload_d     = buf_upd[PADDED_BITS-1 -: PAYLOAD_BITS];
      payload_valid_d = 1'b1;
      if (good_cnt_q != 16'hFFFF) begin
        good_cnt_d = good_cnt_q + 16'd1;
      end
    end
    if (reject) begin
      len_err_d = 1'b1;
      if (err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end
  end

  assign o_payload     = o_payload_q;
  assign payload_valid = payload_valid_q;
  assign len_err       = len_err_q;
  assign good_cnt      = good_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_net_udp_rx_unpack.sv
// ---------------------------------------------------------------------------
// tb_net_udp_rx_unpack
//
// Directed testbench for net_udp_rx_unpack, using the default parameters.
// Each table row drives one cycle of inputs and then lists the outputs
// expected after the next clock edge. After the table, two hand-written
// sequences cover multi-cycle behaviour: how long o_payload is held, and how
// a dropped packet stays dropped across idle gaps.
// ---------------------------------------------------------------------------
module tb_net_udp_rx_unpack;

  localparam logic [87:0] P1 = 88'h0123456789ABCDEFFEDCBA;
  localparam logic [87:0] P2 = 88'hAAAAAAAABBBBBBBBCC0000;

`ifdef UDP_RX_PAD_CHECK_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic        gmii_rx_clk;
  logic        rst;
  logic        rec_en;
  logic [31:0] rec_data;
  logic        rec_pkt_done;
  logic [15:0] rec_byte_num;
  logic [87:0] o_payload;
  logic        payload_valid;
  logic        len_err;
  logic [15:0] good_cnt;
  logic [15:0] err_cnt;

  int n_vec = 0;
  int n_bad = 0;

  net_udp_rx_unpack dut (
    .gmii_rx_clk  (gmii_rx_clk),
    .rst          (rst),
    .rec_en       (rec_en),
    .rec_data     (rec_data),
    .rec_pkt_done (rec_pkt_done),
    .rec_byte_num (rec_byte_num),
    .o_payload    (o_payload),
    .payload_valid(payload_valid),
    .len_err      (len_err),
    .good_cnt     (good_cnt),
    .err_cnt      (err_cnt)
  );

  initial gmii_rx_clk = 1'b0;
  always #5 gmii_rx_clk = ~gmii_rx_clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] data;
    logic        done;
    logic [15:0] bn;
    logic        pv;
    logic        le;
    logic [87:0] pay;
    logic [15:0] gc;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[$];

  function automatic void push(logic r, logic en, logic [31:0] d, logic dn,
                               logic [15:0] bn, logic pv, logic le,
                               logic [87:0] pay, logic [15:0] gc,
                               logic [15:0] ec);
    vec_t v;
    v.rst = r; v.en = en; v.data = d; v.done = dn; v.bn = bn;
    v.pv = pv; v.le = le; v.pay = pay; v.gc = gc; v.ec = ec;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs at the falling edge, then sample just after
  // the rising edge.
  task automatic step(logic r, logic en, logic [31:0] d, logic dn,
                      logic [15:0] bn);
    @(negedge gmii_rx_clk);
    rst          = r;
    rec_en       = en;
    rec_data     = d;
    rec_pkt_done = dn;
    rec_byte_num = bn;
    @(posedge gmii_rx_clk);
    #1;
  endtask

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [87:0] pay41, pay_h;
    logic        pv41, le41;
    logic [15:0] gc41, ec41, gc45, ec45;
    int          lat;

    rst = 1'b1; rec_en = 1'b0; rec_data = '0; rec_pkt_done = 1'b0;
    rec_byte_num = '0;

    // Row 41 is where the build option changes the outcome.
    pv41  = PAD_EN ? 1'b0 : 1'b1;
    le41  = PAD_EN ? 1'b1 : 1'b0;
    pay41 = PAD_EN ? P2 : P1;
    gc41  = PAD_EN ? 16'd1 : 16'd2;
    ec41  = PAD_EN ? 16'd1 : 16'd0;
    gc45  = gc41;
    ec45  = ec41 + 16'd1;

    //   rst en data          done bn      pv le pay gc ec
    // reset
    push(1, 0, 32'h0,        0, 16'd0,  0, 0, '0, 0, 0);
    push(1, 0, 32'h0,        0, 16'd0,  0, 0, '0, 0, 0);
    // good packet, done on the cycle after the last word
    push(0, 1, 32'h01234567, 0, 16'd0,  0, 0, '0, 0, 0);
    push(0, 1, 32'h89ABCDEF, 0, 16'd0,  0, 0, '0, 0, 0);
    push(0, 1, 32'hFEDCBA00, 0, 16'd0,  0, 0, '0, 0, 0);
    push(0, 0, 32'h0,        1, 16'd11, 1, 0, P1, 1, 0);
    push(0, 0, 32'h0,        0, 16'd0,  0, 0, P1, 1, 0);
    // good packet, done on the same cycle as the last word
    push(0, 1, 32'h01234567, 0, 16'd0,  0, 0, P1, 1, 0);
    push(0, 1, 32'h89ABCDEF, 0, 16'd0,  0, 0, P1, 1, 0);
    push(0, 1, 32'hFEDCBA00, 1, 16'd11, 1, 0, P1, 2, 0);
    push(0, 0, 32'h0,        0, 16'd0,  0, 0, P1, 2, 0);
    // four words: overflow, reject; then a back-to-back good packet
    push(0, 1, 32'h01234567, 0, 16'd0,  0, 0, P1, 2, 0);
    push(0, 1, 32'h89ABCDEF, 0, 16'd0,  0, 0, P1, 2, 0);
    push(0, 1, 32'hFEDCBA00, 0, 16'd0,  0, 0, P1, 2, 0);
    push(0, 1, 32'h11111111, 0, 16'd0,  0, 0, P1, 2, 0);
    push(0, 0, 32'h0,        1, 16'd11, 0, 1, P1, 2, 1);
    push(0, 1, 32'hAAAAAAAA, 0, 16'd0,  0, 0, P1, 2, 1);
    push(0, 1, 32'hBBBBBBBB, 0, 16'd0,  0, 0, P1, 2, 1);
    push(0, 1, 32'hCC000000, 0, 16'd0,  0, 0, P1, 2, 1);
    push(0, 0, 32'h0,        1, 16'd11, 1, 0, P2, 3, 1);
    // wrong byte count, then done with no words
    push(0, 1, 32'h01234567, 0, 16'd0,  0, 0, P2, 3, 1);
    push(0, 1, 32'h89ABCDEF, 0, 16'd0,  0, 0, P2, 3, 1);
    push(0, 1, 32'hFEDCBA00, 0, 16'd0,  0, 0, P2, 3, 1);
    push(0, 0, 32'h0,        1, 16'd10, 0, 1, P2, 3, 2);
    push(0, 0, 32'h0,        1, 16'd11, 0, 1, P2, 3, 3);
    push(0, 0, 32'h0,        0, 16'd0,  0, 0, P2, 3, 3);
    // overflow word arriving together with done
    push(0, 1, 32'h01234567, 0, 16'd0,  0, 0, P2, 3, 3);
    push(0, 1, 32'h89ABCDEF, 0, 16'd0,  0, 0, P2, 3, 3);
    push(0, 1, 32'hFEDCBA00, 0, 16'd0,  0, 0, P2, 3, 3);
    push(0, 1, 32'h22222222, 1, 16'd11, 0, 1, P2, 3, 4);
    // reset mid-packet; the partial packet must not leak into the next one
    push(0, 1, 32'h01234567, 0, 16'd0,  0, 0, P2, 3, 4);
    push(0, 1, 32'h89ABCDEF, 0, 16'd0,  0, 0, P2, 3, 4);
    push(1, 0, 32'h0,        0, 16'd0,  0, 0, '0, 0, 0);
    push(1, 0, 32'h0,        0, 16'd0,  0, 0, '0, 0, 0);
    push(0, 1, 32'hAAAAAAAA, 0, 16'd0,  0, 0, '0, 0, 0);
    push(0, 1, 32'hBBBBBBBB, 0, 16'd0,  0, 0, '0, 0, 0);
    push(0, 1, 32'hCC000000, 0, 16'd0,  0, 0, '0, 0, 0);
    push(0, 0, 32'h0,        1, 16'd11, 1, 0, P2, 1, 0);
    // nonzero padding bits
    push(0, 1, 32'h01234567, 0, 16'd0,  0, 0, P2, 1, 0);
    push(0, 1, 32'h89ABCDEF, 0, 16'd0,  0, 0, P2, 1, 0);
    push(0, 1, 32'hFEDCBA01, 0, 16'd0,  0, 0, P2, 1, 0);
    push(0, 0, 32'h0,        1, 16'd11, pv41, le41, pay41, gc41, ec41);
    push(0, 0, 32'h0,        0, 16'd0,  0, 0, pay41, gc41, ec41);
    // short packet (two words) with the correct byte count
    push(0, 1, 32'h01234567, 0, 16'd0,  0, 0, pay41, gc41, ec41);
    push(0, 1, 32'h89ABCDEF, 0, 16'd0,  0, 0, pay41, gc41, ec41);
    push(0, 0, 32'h0,        1, 16'd11, 0, 1, pay41, gc45, ec45);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].data, vecs[i].done, vecs[i].bn);
      check($sformatf("row%0d {pv,le,pay,gc,ec}", i),
            128'({payload_valid, len_err, o_payload, good_cnt, err_cnt}),
            128'({vecs[i].pv, vecs[i].le, vecs[i].pay, vecs[i].gc, vecs[i].ec}));
    end

    // Hand sequence 1: a good packet. Measure the latency from done to
    // payload_valid (bounded), then check that the strobe lasts one cycle
    // and that o_payload is held afterwards.
    step(0, 1, 32'hAAAAAAAA, 0, 16'd0);
    step(0, 1, 32'hBBBBBBBB, 0, 16'd0);
    step(0, 1, 32'hCC000000, 0, 16'd0);
    step(0, 0, 32'h0, 1, 16'd11);
    lat = 1;
    while (!payload_valid && lat < 8) begin
      step(0, 0, 32'h0, 0, 16'd0);
      lat++;
    end
    check("seq1 latency", 128'(lat), 128'(1));
    check("seq1 payload", 128'(o_payload), 128'(P2));
    check("seq1 good_cnt", 128'(good_cnt), 128'(gc45 + 16'd1));
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 32'h0, 0, 16'd0);
      check($sformatf("seq1 idle%0d {pv,le,pay}", k),
            128'({payload_valid, len_err, o_payload}), 128'({2'b00, P2}));
    end

    // Hand sequence 2: five words with idle gaps between them, so the
    // packet overflows and is dropped. Nothing may strobe until done, and
    // done must then reject the packet.
    pay_h = o_payload;
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 32'h01234567 + 32'(k), 0, 16'd0);
      step(0, 0, 32'h0, 0, 16'd0);
      check($sformatf("seq2 gap%0d {pv,le}", k),
            128'({payload_valid, len_err}), 128'(2'b00));
    end
    step(0, 0, 32'h0, 1, 16'd11);
    check("seq2 reject {pv,le,pay}",
          128'({payload_valid, len_err, o_payload}), 128'({2'b01, pay_h}));
    check("seq2 err_cnt", 128'(err_cnt), 128'(ec45 + 16'd1));
    step(0, 0, 32'h0, 0, 16'd0);
    check("seq2 after {pv,le}", 128'({payload_valid, len_err}), 128'(2'b00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
